fpu_dispatch: RTL and testbench
===============================

Name: fpu_dispatch

Overview:
- Sequencing controller between the CPU execute stage and the four FP units (fadd, fsub, fmul, fdiv), each with AXI4-Stream a, b and result channels.
- Accepts one tagged FP request per cycle, drives the operand channels of the selected unit, and tracks outstanding ops in an in-order queue.
- Returns results to the CPU strictly in issue order, with tag.
- Replaces the per-op en/done glue, so the CPU can issue back-to-back FP ops without stalling in a dedicated FPU state.

Parameters:
TAG_W, 5, width of request/response tag (destination register index)
DEPTH, 4, max outstanding ops (power of 2, ≥2)
TIMEOUT, 255, watchdog limit in cycles (used only with FPU_TIMEOUT_EN)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when both high
req_op  in  2  0=fadd 1=fsub 2=fmul 3=fdiv (lane index)
req_a  in  32  operand a
req_b  in  32  operand b
req_tag  in  TAG_W  returned with result
rsp_valid  out  1  result present
rsp_ready  in  1  result consumed when both high
rsp_data  out  32  result
rsp_tag  out  TAG_W  tag of result
rsp_err  out  1  timeout result (0 when feature off)
busy  out  1  any op pending or response held
unit_a_tdata  out  128  lane k = bits [32k+31:32k]
unit_a_tvalid  out  4  per lane
unit_a_tready  in  4  per lane
unit_b_tdata  out  128  as a
unit_b_tvalid  out  4
unit_b_tready  in  4
unit_res_tdata  in  128
unit_res_tvalid  in  4
unit_res_tready  out  4

Behaviour:
- Reset: all tvalid/tready outputs 0; rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0; queue count=0; busy=0; unit_*_tdata=0. In-flight ops are dropped; the FP units share rstn.
- req_ready = (count < DEPTH) && no lane has a_tvalid or b_tvalid high. It is registered-state only, with no combinational path from req_*.
- Accept in cycle N: latch req_a/req_b into lane req_op and push {req_op, req_tag} into the order queue. In cycle N+1, a_tvalid[op] and b_tvalid[op] are both 1.
- Each of a_tvalid and b_tvalid drops independently the cycle after its own tready is seen high. tdata holds stable while tvalid is high, and holds its last value afterward.
- Result path:
  - Only the lane named by the queue head may have res_tready=1; all others are 0.
  - res_tready[head] = count≠0 && (!rsp_valid || rsp_ready).
  - On res_tvalid && res_tready in cycle M: rsp_valid=1, rsp_data and rsp_tag valid in M+1, and the queue pops.
- rsp_valid holds, with data stable, until rsp_ready. Capture is allowed in the same cycle as rsp_ready, giving 1 result/cycle throughput.
- Push and pop in the same cycle: count unchanged. The queue pointers are log2(DEPTH)-bit and wrap naturally.
- Repeated ops to the same unit are legal. Units are pipelined and in-order per lane.
- Results on non-head lanes are back-pressured, never lost.
- busy = count≠0 || rsp_valid || any a/b tvalid.
- Empty queue: all res_tready=0. A stray res_tvalid is ignored.

Optional Feature:
FPU_TIMEOUT_EN:
- Defined: a counter resets on each pop and increments while count≠0 and no head result is captured.
- At count==TIMEOUT (with the rsp register free), the block emits rsp_valid with rsp_data=32'h7FC00000, the head tag, rsp_err=1, then pops the head.
- A late result from that lane for the timed-out op must be drained: the block asserts res_tready for one beat and discards it, tracked with a per-lane discard counter.
- Undefined: no counter and no discard logic; rsp_err is tied 0.

Test Plan:
- Single fadd: req_op=0, a=3F800000, b=40000000, tag=7 → a/b tvalid[0] next cycle; unit returns 40400000 → rsp_valid next cycle with rsp_data=40400000, rsp_tag=7.
- Out-of-order units: issue fdiv (tag 1) then fadd (tag 2). fadd result arrives first → held (res_tready[0]=0) until fdiv result; rsp order is tag 1 then tag 2.
- Full queue: issue 4 ops with rsp_ready=0 → req_ready=0 on the 5th. Pulse rsp_ready once → one pop, req_ready returns to 1.
- Split operand handshake: a_tready[2]=1 at cycle 1, b_tready[2]=1 at cycle 4 → a_tvalid drops at 2, b_tvalid at 5, req_ready=0 until 5.
- Reset mid-op: 3 outstanding, assert rstn=0 for 1 cycle → count=0, busy=0, all tvalid=0, rsp_valid=0.
- FPU_TIMEOUT_EN, TIMEOUT=16: fmul never responds → rsp_valid with rsp_err=1, data 7FC00000 at cycle 17. A late result is then discarded without producing a response.

Source files
------------

// File: rtl/fpu_dispatch.sv
// In-order dispatch between the CPU execute stage and four AXI4-Stream FP units (fadd/fsub/fmul/fdiv).
// Optional head-of-queue watchdog with late-result draining: define FPU_TIMEOUT_EN.
module fpu_dispatch #(
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [31:0]        req_a,
  input  logic [31:0]        req_b,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_err,
  output logic               busy,
  output logic [127:0]       unit_a_tdata,
  output logic [3:0]         unit_a_tvalid,
  input  logic [3:0]         unit_a_tready,
  output logic [127:0]       unit_b_tdata,
  output logic [3:0]         unit_b_tvalid,
  input  logic [3:0]         unit_b_tready,
  input  logic [127:0]       unit_res_tdata,
  input  logic [3:0]         unit_res_tvalid,
  output logic [3:0]         unit_res_tready
);

  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_param_err
    $error("fpu_dispatch: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef struct packed {
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } ord_t;

  logic [LANES-1:0][DW-1:0] a_data, b_data, res_data;
  logic [LANES-1:0]         a_valid, b_valid;
  logic [LANES-1:0]         res_ready_c;
  ord_t                     q [DEPTH];
  ord_t                     head;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count;
  logic                     push, pop, head_ok, capture, fire;

  assign head      = q[rd_ptr];
  assign res_data  = unit_res_tdata;
  assign req_ready = (count < CW'(DEPTH)) && !(|a_valid) && !(|b_valid);
  assign push      = req_valid && req_ready;
  assign head_ok   = (count != '0) && (!rsp_valid || rsp_ready);
  assign pop       = capture || fire;
  assign busy      = (count != '0) || rsp_valid || (|a_valid) || (|b_valid);

  assign unit_a_tdata    = a_data;
  assign unit_b_tdata    = b_data;
  assign unit_a_tvalid   = a_valid;
  assign unit_b_tvalid   = b_valid;
  assign unit_res_tready = res_ready_c;

`ifdef FPU_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0]            tmo_cnt;
  logic [LANES-1:0][CW-1:0] drop_cnt;

  // Lanes owing a late beat for a timed-out op drain it before serving the head.
  always_comb begin
    res_ready_c = '0;
    capture     = 1'b0;
    for (int k = 0; k < LANES; k++) res_ready_c[k] = (drop_cnt[k] != '0);
    if (drop_cnt[head.op] == '0) begin
      res_ready_c[head.op] = head_ok;
      capture              = head_ok && unit_res_tvalid[head.op];
    end
    fire = head_ok && !capture && (tmo_cnt == TW'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop || count == '0) tmo_cnt <= '0;
      else if (tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
      for (int k = 0; k < LANES; k++)
        drop_cnt[k] <= drop_cnt[k] + CW'(fire && head.op == 2'(k))
                                   - CW'(drop_cnt[k] != '0 && unit_res_tvalid[k]);
    end
  end
`else
  always_comb begin
    res_ready_c          = '0;
    res_ready_c[head.op] = head_ok;
    capture              = head_ok && unit_res_tvalid[head.op];
    fire                 = 1'b0;
  end
`endif

  // Operand channels: load on accept, each valid clears independently on its own handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_valid <= '0;
      b_valid <= '0;
      a_data  <= '0;
      b_data  <= '0;
    end else begin
      a_valid <= a_valid & ~unit_a_tready;
      b_valid <= b_valid & ~unit_b_tready;
      if (push) begin
        a_valid[req_op] <= 1'b1;
        b_valid[req_op] <= 1'b1;
        a_data[req_op]  <= req_a;
        b_data[req_op]  <= req_b;
      end
    end
  end

  // Issue-order queue of {op, tag}.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      if (push) begin
        q[wr_ptr] <= '{op: req_op, tag: req_tag};
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Response register: reloads in the same cycle it is consumed.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else if (pop) begin
      rsp_valid <= 1'b1;
      rsp_data  <= fire ? 32'h7FC0_0000 : res_data[head.op];
      rsp_tag   <= head.tag;
      rsp_err   <= fire;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed self-checking bench for fpu_dispatch; timeout scenario runs when FPU_TIMEOUT_EN is defined.
module tb_fpu_dispatch;

  localparam int unsigned TAG_W = 5;

  logic               clk = 1'b0;
  logic               rstn;
  logic               req_valid, req_ready;
  logic [1:0]         req_op;
  logic [31:0]        req_a, req_b;
  logic [TAG_W-1:0]   req_tag;
  logic               rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0]        rsp_data;
  logic [TAG_W-1:0]   rsp_tag;
  logic [127:0]       unit_a_tdata, unit_b_tdata, unit_res_tdata;
  logic [3:0]         unit_a_tvalid, unit_a_tready, unit_b_tvalid, unit_b_tready;
  logic [3:0]         unit_res_tvalid, unit_res_tready;

  int n_checks = 0;
  int n_errors = 0;

  fpu_dispatch #(.TAG_W(TAG_W), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy),
    .unit_a_tdata(unit_a_tdata), .unit_a_tvalid(unit_a_tvalid), .unit_a_tready(unit_a_tready),
    .unit_b_tdata(unit_b_tdata), .unit_b_tvalid(unit_b_tvalid), .unit_b_tready(unit_b_tready),
    .unit_res_tdata(unit_res_tdata), .unit_res_tvalid(unit_res_tvalid),
    .unit_res_tready(unit_res_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b0; unit_a_tready = 4'hF; unit_b_tready = 4'hF;
    unit_res_tdata = '0; unit_res_tvalid = '0;
    tick(); tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_a_tvalid", 32'(unit_a_tvalid), 32'd0);
    check("rst_res_tready", 32'(unit_res_tready), 32'd0);
    check("rst_a_tdata", unit_a_tdata[31:0], 32'd0);
    rstn = 1'b1;
    tick();

    // Single fadd
    issue(2'd0, 32'h3F80_0000, 32'h4000_0000, 5'd7);
    check("fadd_a_tvalid", 32'(unit_a_tvalid), 32'h1);
    check("fadd_b_tvalid", 32'(unit_b_tvalid), 32'h1);
    check("fadd_a_tdata", unit_a_tdata[31:0], 32'h3F80_0000);
    check("fadd_b_tdata", unit_b_tdata[31:0], 32'h4000_0000);
    check("fadd_req_ready_blk", 32'(req_ready), 32'd0);
    tick();
    check("fadd_a_drop", 32'(unit_a_tvalid), 32'h0);
    check("fadd_res_tready", 32'(unit_res_tready), 32'h1);
    unit_res_tvalid = 4'b0001; unit_res_tdata[31:0] = 32'h4040_0000;
    tick();
    unit_res_tvalid = '0;
    check("fadd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("fadd_rsp_data", rsp_data, 32'h4040_0000);
    check("fadd_rsp_tag", 32'(rsp_tag), 32'd7);
    check("fadd_rsp_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("fadd_rsp_clear", 32'(rsp_valid), 32'd0);
    check("fadd_busy_idle", 32'(busy), 32'd0);

    // Out-of-order unit completion is reordered
    issue(2'd3, 32'h1, 32'h2, 5'd1);
    tick();
    issue(2'd0, 32'h3, 32'h4, 5'd2);
    tick();
    unit_res_tvalid = 4'b0001; unit_res_tdata[31:0] = 32'h1111_1111;
    #1;
    check("ooo_tready_head", 32'(unit_res_tready), 32'h8);
    tick();
    check("ooo_held", 32'(rsp_valid), 32'd0);
    unit_res_tvalid = 4'b1001; unit_res_tdata[127:96] = 32'h3333_3333;
    tick();
    unit_res_tvalid = 4'b0001;
    check("ooo_first_tag", 32'(rsp_tag), 32'd1);
    check("ooo_first_data", rsp_data, 32'h3333_3333);
    check("ooo_stall_tready", 32'(unit_res_tready), 32'h0);
    rsp_ready = 1'b1;
    #1;
    check("ooo_tready_next", 32'(unit_res_tready), 32'h1);
    tick();
    unit_res_tvalid = '0;
    check("ooo_second_valid", 32'(rsp_valid), 32'd1);
    check("ooo_second_tag", 32'(rsp_tag), 32'd2);
    check("ooo_second_data", rsp_data, 32'h1111_1111);
    tick();
    rsp_ready = 1'b0;
    check("ooo_drained", 32'(rsp_valid), 32'd0);

    // Full queue, then back-to-back drain
    for (int i = 0; i < 4; i++) begin
      issue(2'd2, 32'(i), 32'(i), 5'(10 + i));
      tick();
    end
    check("full_req_ready", 32'(req_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    unit_res_tvalid = 4'b0100; unit_res_tdata[95:64] = 32'hA0A0_A0A0;
    #1;
    check("full_res_tready", 32'(unit_res_tready), 32'h4);
    tick();
    check("full_pop_ready", 32'(req_ready), 32'd1);
    check("full_tag10", 32'(rsp_tag), 32'd10);
    check("full_hold_tready", 32'(unit_res_tready), 32'h0);
    rsp_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("full_b2b_valid", 32'(rsp_valid), 32'd1);
      check("full_b2b_tag", 32'(rsp_tag), 32'(10 + i));
    end
    unit_res_tvalid = '0;
    tick();
    rsp_ready = 1'b0;
    check("full_empty", 32'(busy), 32'd0);

    // Split operand handshake on lane 2
    unit_a_tready = '0; unit_b_tready = '0;
    issue(2'd2, 32'hAAAA_0001, 32'hBBBB_0002, 5'd20);
    check("split_c1_a", 32'(unit_a_tvalid), 32'h4);
    check("split_c1_b", 32'(unit_b_tvalid), 32'h4);
    unit_a_tready = 4'b0100;
    tick();
    unit_a_tready = '0;
    check("split_c2_a", 32'(unit_a_tvalid), 32'h0);
    check("split_c2_b", 32'(unit_b_tvalid), 32'h4);
    check("split_c2_ready", 32'(req_ready), 32'd0);
    tick(); tick();
    check("split_b_stable", unit_b_tdata[95:64], 32'hBBBB_0002);
    check("split_c4_ready", 32'(req_ready), 32'd0);
    unit_b_tready = 4'b0100;
    tick();
    check("split_c5_b", 32'(unit_b_tvalid), 32'h0);
    check("split_c5_ready", 32'(req_ready), 32'd1);
    unit_a_tready = 4'hF; unit_b_tready = 4'hF;

    // Reset with three ops outstanding
    issue(2'd0, 32'h5, 32'h6, 5'd21);
    tick();
    issue(2'd1, 32'h7, 32'h8, 5'd22);
    check("mid_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mid_busy_clr", 32'(busy), 32'd0);
    check("mid_a_tvalid", 32'(unit_a_tvalid), 32'h0);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd1);
    unit_res_tvalid = 4'hF;
    #1;
    check("stray_tready", 32'(unit_res_tready), 32'h0);
    tick();
    unit_res_tvalid = '0;
    check("stray_ignored", 32'(rsp_valid), 32'd0);

`ifdef FPU_TIMEOUT_EN
    begin
      int waited;
      waited = 0;
      issue(2'd2, 32'h1, 32'h2, 5'd9);
      while (!rsp_valid && waited < 60) begin
        tick();
        waited++;
      end
      check("tmo_seen", 32'(rsp_valid), 32'd1);
      check("tmo_err", 32'(rsp_err), 32'd1);
      check("tmo_data", rsp_data, 32'h7FC0_0000);
      check("tmo_tag", 32'(rsp_tag), 32'd9);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      unit_res_tvalid = 4'b0100; unit_res_tdata[95:64] = 32'h1234_5678;
      #1;
      check("tmo_drain_tready", 32'(unit_res_tready), 32'h4);
      tick();
      unit_res_tvalid = '0;
      check("tmo_late_dropped", 32'(rsp_valid), 32'd0);
      check("tmo_idle", 32'(busy), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
